// File: rtl/Common.sv
// rtl/Common.sv - shared constants, register index type and writeback bundle
package Common;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;

  typedef logic [4:0] RegIdx;

  // Writeback-stage bundle; the register file consumes all three fields.
  typedef struct packed {
    logic            wback;
    RegIdx           wreg;
    logic [XLEN-1:0] wdata;
  } Signals;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register in-flight write counter, saturating up/down
module sb_counter #(
  parameter int MAXPEND = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] count_o,
  output logic       underflow_o
);

  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       dec_eff;

  // Next count: a writeback only retires a pending write when one exists;
  // a simultaneous retire and new issue cancel out.
  always_comb begin
    dec_eff = dec_i && (count_q != 2'd0);
    count_d = count_q;
    if (inc_i && !dec_eff && (count_q != 2'(MAXPEND))) begin
      count_d = count_q + 2'd1;
    end else if (dec_eff && !inc_i) begin
      count_d = count_q - 2'd1;
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign underflow_o = dec_i && (count_q == 2'd0);

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file with writeback bypass and pending-write scoreboard
module reg_file #(
  parameter int NREGS   = Common::NREGS,
  parameter int XLEN    = Common::XLEN,
  parameter int MAXPEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  Common::Signals    i_signals,
  input  logic              issue_valid,
  input  Common::RegIdx     issue_rs1,
  input  Common::RegIdx     issue_rs2,
  input  logic              issue_use1,
  input  logic              issue_use2,
  input  Common::RegIdx     issue_rd,
  input  logic              issue_wen,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  output logic              stall,
  output logic              err
);

  import Common::*;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [1:0]       pend   [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] under;
  logic             err_q;
  logic             err_d;
  logic             wb_en;
  logic             accept;
  logic             hz1;
  logic             hz2;
  logic             full;

  assign wb_en  = i_signals.wback && (i_signals.wreg != RegIdx'(0));
  assign accept = issue_valid && !stall;

  // x0 never has writes in flight.
  assign pend[0]  = 2'd0;
  assign inc[0]   = 1'b0;
  assign under[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    logic wb_hit;
    assign wb_hit = wb_en && (i_signals.wreg == RegIdx'(g));
    assign inc[g] = accept && issue_wen && (issue_rd == RegIdx'(g));
    sb_counter #(
      .MAXPEND(MAXPEND)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc[g]),
      .dec_i      (wb_hit),
      .count_o    (pend[g]),
      .underflow_o(under[g])
    );
  end

  // Issue hold: a source still waiting on an older write, unless the last
  // outstanding write lands this cycle and is bypassed; or the destination
  // already has the maximum number of writes in flight.
  always_comb begin
    hz1 = issue_use1 && (issue_rs1 != RegIdx'(0)) && (pend[issue_rs1] != 2'd0) &&
          !((pend[issue_rs1] == 2'd1) && wb_en && (i_signals.wreg == issue_rs1));
    hz2 = issue_use2 && (issue_rs2 != RegIdx'(0)) && (pend[issue_rs2] != 2'd0) &&
          !((pend[issue_rs2] == 2'd1) && wb_en && (i_signals.wreg == issue_rs2));
    full = issue_wen && (issue_rd != RegIdx'(0)) && (pend[issue_rd] == 2'(MAXPEND)) &&
           !(wb_en && (i_signals.wreg == issue_rd));
    stall = issue_valid && (hz1 || hz2 || full);
  end

  // Register storage; x0 stays zero because writes to it are never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[i_signals.wreg] <= i_signals.wdata;
    end
  end

  // Read ports: x0 reads zero, a same-cycle writeback wins over storage.
  always_comb begin
    if (issue_rs1 == RegIdx'(0)) begin
      rdata1 = '0;
    end else if (wb_en && (i_signals.wreg == issue_rs1)) begin
      rdata1 = i_signals.wdata;
    end else begin
      rdata1 = regs_q[issue_rs1];
    end
    if (issue_rs2 == RegIdx'(0)) begin
      rdata2 = '0;
    end else if (wb_en && (i_signals.wreg == issue_rs2)) begin
      rdata2 = i_signals.wdata;
    end else begin
      rdata2 = regs_q[issue_rs2];
    end
  end

  assign err_d = err_q || (|under);

  // Sticky flag for a writeback that had no matching in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter NREGS, default 32, giving the number of architectural registers (index 0 hardwired zero).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the register data width in bits.
REQ-003 The block SHALL have parameter MAXPEND, default 3, giving the maximum in-flight writes per register.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its posedge.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port i_signals, input, Signals: writeback-stage output; only fields wback, wreg, wdata are consumed.
REQ-007 Port issue_valid, input, 1 bit: decode presents an instruction this cycle.
REQ-008 Port issue_rs1 and issue_rs2, input, 5 bits each: source register indices.
REQ-009 Port issue_use1 and issue_use2, input, 1 bit each: the source is actually read.
REQ-010 Port issue_rd, input, 5 bits, and issue_wen, input, 1 bit: destination index and destination-write flag.
REQ-011 Port rdata1 and rdata2, output, XLEN bits: source operand values.
REQ-012 Port stall, output, 1 bit: issue must be held this cycle.
REQ-013 Port err, output, 1 bit: sticky underflow flag.

Function
REQ-014 A write SHALL occur at posedge when i_signals.wback=1 and i_signals.wreg!=0, storing wdata into regs[wreg]; writes to index 0 SHALL be ignored.
REQ-015 Reads SHALL be combinational: index 0 yields 0; otherwise, if wback=1 and wreg equals the index, yield wdata (same-cycle bypass); otherwise yield regs[index].
REQ-016 Each register 1..NREGS-1 SHALL have a pending counter, 2 bits wide, range 0..MAXPEND.
REQ-017 An issue SHALL be accepted when issue_valid=1 and stall=0.
REQ-018 On an accepted issue with issue_wen=1 and issue_rd!=0, pend[rd] SHALL increment.
REQ-019 On a writeback with wreg!=0 and pend[wreg]>0, pend[wreg] SHALL decrement.
REQ-020 If an increment and a decrement target the same register in one cycle, pend SHALL stay unchanged.
REQ-021 A source is hazarded when it is used, its index !=0 and pend>0, EXCEPT when pend==1 and a writeback to that index occurs this cycle; that case is resolved by bypass.
REQ-022 stall SHALL be 1 when issue_valid=1 and (either source is hazarded, or issue_wen=1 with issue_rd!=0 and pend[rd]==MAXPEND with no same-cycle writeback to rd); otherwise stall SHALL be 0.
REQ-023 A writeback to a register with pend==0 and wreg!=0 SHALL still update data, SHALL leave pend at 0, and SHALL set err.
REQ-024 err SHALL remain 1 until reset.
REQ-025 The block SHALL have zero-cycle read latency and one-cycle write latency; a write SHALL be visible via storage on the following cycle and via bypass in the same cycle.

Reset
REQ-026 While rst=1 at posedge, all regs SHALL be cleared to 0, all pend counters to 0, and err to 0; any writeback or issue in that cycle SHALL be discarded.
REQ-027 After reset, rdata1 and rdata2 SHALL read 0 for every index, and stall SHALL be 0.

Structure
REQ-028 The constants NREGS and XLEN and the RegIdx type (5-bit) SHALL live in package Common, alongside the existing Signals struct.
REQ-029 The per-register up/down saturating counter SHALL be one sub-module, sb_counter, instantiated NREGS-1 times.

Verification
REQ-030 Scenario: reset, then wback=1, wreg=5, wdata=0xDEADBEEF, rs1=5 in the same cycle -> rdata1=0xDEADBEEF that cycle and on the next cycle from storage.
REQ-031 Scenario: wback=1, wreg=0, wdata=0x1234 -> a read of x0 stays 0 and err stays 0.
REQ-032 Scenario: issue rd=7 wen=1; next cycle issue rs1=7 use1=1 -> stall=1; when wback to wreg=7 occurs -> stall=0 that cycle and rdata1=wdata.
REQ-033 Scenario: three accepted issues to rd=3 with no writeback -> a fourth issue to rd=3 gives stall=1; one writeback to 3 in that cycle -> stall=0 and pend stays at 3.
REQ-034 Scenario: writeback to wreg=9 with pend[9]=0 -> regs[9] updated and err=1 persisting; rst=1 -> err=0 and regs[9]=0.
